// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {PRST, WLOCK, STABLE, RUN, FAIL} pll_ctrl_state_t;

   localparam int RETRY_W = 8;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // A single-cycle phase still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pll_ctrl_sync_ff.sv
// Two-flop synchronizer for slow asynchronous level signals.
module sync_ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/pll_ctrl.sv
// PLL lock supervisor: holds the PLL in reset, waits for stable lock with
// bounded retries, then releases the downstream reset.
module pll_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 100000,
   parameter int LOCK_STABLE    = 1024,
   parameter int MAX_RETRY      = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               lock_i,
   input  logic               restart_i,
   output logic               pll_rst_o,
   output logic               rst_n_o,
   output logic               locked_o,
   output logic               lock_lost_o,
   output logic               fail_o,
   output logic [RETRY_W-1:0] retry_cnt_o
);

   localparam int CNT_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE));
   localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

   pll_ctrl_state_t    state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [RETRY_W-1:0] retry_reg, retry_next;
   logic               pll_rst_reg, pll_rst_next;
   logic               rst_n_reg, rst_n_next;
   logic               lock_lost_reg, lock_lost_next;
   logic               fail_reg, fail_next;
   logic               lock_s;

   sync_ff #(
      .WIDTH(1)
   ) u_lock_sync (
      .clk(clk_i),
      .rst(rst_i),
      .d  (lock_i),
      .q  (lock_s)
   );

   always_comb begin
      state_next     = state_reg;
      retry_next     = retry_reg;
      lock_lost_next = 1'b0;

      if (restart_i) begin
         state_next = PRST;
         retry_next = '0;
      end else begin
         unique case (state_reg)
            PRST: begin
               if (cnt_reg == RST_LAST) state_next = WLOCK;
            end
            WLOCK: begin
               if (lock_s) begin
                  state_next = STABLE;
               end else if (cnt_reg == TIMEOUT_LAST) begin
                  if (retry_reg >= RETRY_MAX) begin
                     state_next = FAIL;
                  end else begin
                     state_next = PRST;
                     retry_next = retry_reg + 1'b1;
                  end
               end
            end
            STABLE: begin
               // A lock glitch counts as a failed attempt, even on the final count.
               if (!lock_s) begin
                  if (retry_reg >= RETRY_MAX) begin
                     state_next = FAIL;
                  end else begin
                     state_next = PRST;
                     retry_next = retry_reg + 1'b1;
                  end
               end else if (cnt_reg == STABLE_LAST) begin
                  state_next = RUN;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_next     = PRST;
                  retry_next     = '0;
                  lock_lost_next = 1'b1;
               end
            end
            FAIL: begin
               state_next = FAIL;
            end
            default: begin
               state_next = PRST;
               retry_next = '0;
            end
         endcase
      end

      if (restart_i || (state_next != state_reg) || (state_reg == RUN) || (state_reg == FAIL))
         cnt_next = '0;
      else
         cnt_next = cnt_reg + 1'b1;

      pll_rst_next = (state_next == PRST) || (state_next == FAIL);
      rst_n_next   = (state_next == RUN);
      fail_next    = (state_next == FAIL);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg     <= PRST;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         pll_rst_reg   <= 1'b1;
         rst_n_reg     <= 1'b0;
         lock_lost_reg <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         retry_reg     <= retry_next;
         pll_rst_reg   <= pll_rst_next;
         rst_n_reg     <= rst_n_next;
         lock_lost_reg <= lock_lost_next;
         fail_reg      <= fail_next;
      end
   end

   assign pll_rst_o   = pll_rst_reg;
   assign rst_n_o     = rst_n_reg;
   assign locked_o    = lock_s;
   assign lock_lost_o = lock_lost_reg;
   assign fail_o      = fail_reg;
   assign retry_cnt_o = retry_reg;

endmodule

// File: tb/tb_pll_ctrl.sv
// Directed bench for pll_ctrl: cycle table for lock-up and loss in RUN,
// hand sequences for glitch, restart, async reset and the no-lock path.
module tb_pll_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       lock_i;
   logic       restart_i;
   logic       pll_rst_o;
   logic       rst_n_o;
   logic       locked_o;
   logic       lock_lost_o;
   logic       fail_o;
   logic [7:0] retry_cnt_o;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        lock;
      logic        restart;
      logic [12:0] exp;
   } vec_t;

   vec_t vecs[$];

   always #5 clk_i = ~clk_i;

   pll_ctrl #(
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (20),
      .LOCK_STABLE   (8),
      .MAX_RETRY     (2)
   ) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .lock_i     (lock_i),
      .restart_i  (restart_i),
      .pll_rst_o  (pll_rst_o),
      .rst_n_o    (rst_n_o),
      .locked_o   (locked_o),
      .lock_lost_o(lock_lost_o),
      .fail_o     (fail_o),
      .retry_cnt_o(retry_cnt_o)
   );

   function automatic logic [12:0] mk(input logic pll, input logic rstn, input logic lck,
                                      input logic lost, input logic fl, input logic [7:0] retry);
      return {pll, rstn, lck, lost, fl, retry};
   endfunction

   task automatic check(input string name, input logic [12:0] exp);
      logic [12:0] act;
      act = {pll_rst_o, rst_n_o, locked_o, lock_lost_o, fail_o, retry_cnt_o};
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got pll_rst=%b rst_n=%b locked=%b lock_lost=%b fail=%b retry=%0d, want pll_rst=%b rst_n=%b locked=%b lock_lost=%b fail=%b retry=%0d",
                  name, act[12], act[11], act[10], act[9], act[8], act[7:0],
                  exp[12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
      end else begin
         $display("ok   %s: pll_rst=%b rst_n=%b locked=%b lock_lost=%b fail=%b retry=%0d",
                  name, act[12], act[11], act[10], act[9], act[8], act[7:0]);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic add(input int n, input logic lock, input logic [12:0] exp);
      vec_t v;
      v.lock    = lock;
      v.restart = 1'b0;
      v.exp     = exp;
      repeat (n) vecs.push_back(v);
   endtask

   initial begin
      rst_i     = 1'b1;
      lock_i    = 1'b0;
      restart_i = 1'b0;
      #2;
      check("reset", mk(1, 0, 0, 0, 0, 0));

      // One row per clock after reset release: lock up, reach RUN, then lose lock.
      add(3, 0, mk(1, 0, 0, 0, 0, 0));   // PRST cnt 1..3
      add(6, 0, mk(0, 0, 0, 0, 0, 0));   // WLOCK, lock low for 5 clocks after release
      add(1, 1, mk(0, 0, 0, 0, 0, 0));   // lock_i rises, first sync flop
      add(9, 1, mk(0, 0, 1, 0, 0, 0));   // synced, then STABLE cnt 0..7
      add(5, 1, mk(0, 1, 1, 0, 0, 0));   // RUN, 11 clocks after lock_i rose
      add(1, 0, mk(0, 1, 1, 0, 0, 0));   // lock_i falls
      add(1, 0, mk(0, 1, 0, 0, 0, 0));   // lock_s low, state still RUN
      add(1, 0, mk(1, 0, 0, 1, 0, 0));   // third clock: PRST with lock_lost pulse
      add(3, 0, mk(1, 0, 0, 0, 0, 0));   // pll reset held 4 clocks total
      add(3, 0, mk(0, 0, 0, 0, 0, 0));   // WLOCK again, retry still 0

      @(negedge clk_i);
      rst_i = 1'b0;
      for (int i = 0; i < vecs.size(); i++) begin
         lock_i    = vecs[i].lock;
         restart_i = vecs[i].restart;
         step(1);
         check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Restart from WLOCK with lock present, then glitch lock so the FSM sees it at STABLE cnt=5.
      lock_i    = 1'b1;
      restart_i = 1'b1;
      step(1);
      restart_i = 1'b0;
      check("restart_wlock", mk(1, 0, 0, 0, 0, 0));
      step(4);
      check("glitch_wlock", mk(0, 0, 1, 0, 0, 0));
      step(1);
      check("glitch_stable_entry", mk(0, 0, 1, 0, 0, 0));
      step(3);
      lock_i = 1'b0;
      step(1);
      lock_i = 1'b1;
      step(1);
      check("glitch_lock_s_low", mk(0, 0, 0, 0, 0, 0));
      step(1);
      check("glitch_to_prst", mk(1, 0, 1, 0, 0, 1));
      step(12);
      check("glitch_relock_stable", mk(0, 0, 1, 0, 0, 1));
      step(1);
      check("glitch_relock_run", mk(0, 1, 1, 0, 0, 1));

      // restart_i while in RUN
      restart_i = 1'b1;
      step(1);
      restart_i = 1'b0;
      check("restart_run", mk(1, 0, 1, 0, 0, 0));

      // Async reset pulse between edges while in STABLE cnt=3
      step(8);
      check("pre_rst_stable", mk(0, 0, 1, 0, 0, 0));
      #2;
      rst_i = 1'b1;
      #1;
      check("async_rst_immediate", mk(1, 0, 0, 0, 0, 0));
      #2;
      rst_i = 1'b0;
      step(3);
      check("post_rst_prst", mk(1, 0, 1, 0, 0, 0));
      step(1);
      check("post_rst_release", mk(0, 0, 1, 0, 0, 0));
      step(8);
      check("post_rst_stable", mk(0, 0, 1, 0, 0, 0));
      step(1);
      check("post_rst_run", mk(0, 1, 1, 0, 0, 0));

      // No lock at all: three attempts, then FAIL
      lock_i = 1'b0;
      rst_i  = 1'b1;
      #3;
      check("nolock_reset", mk(1, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      rst_i = 1'b0;
      for (int e = 1; e <= 90; e++) begin
         logic       pll;
         logic       fl;
         logic [7:0] rt;
         pll = (e < 4) || (e >= 24 && e < 28) || (e >= 48 && e < 52) || (e >= 72);
         fl  = (e >= 72);
         rt  = (e < 24) ? 8'd0 : (e < 48) ? 8'd1 : 8'd2;
         step(1);
         check($sformatf("nolock_e%0d", e), mk(pll, 0, 0, 0, fl, rt));
      end

      // FAIL ignores a late lock; only restart_i leaves it
      lock_i = 1'b1;
      step(5);
      check("fail_holds", mk(1, 0, 1, 0, 1, 2));
      restart_i = 1'b1;
      step(1);
      restart_i = 1'b0;
      check("restart_fail", mk(1, 0, 1, 0, 0, 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
